// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared frame widths, register map and controller state encoding
//  Revision : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;

    localparam logic SPI_CMD_WRITE = 1'b1;

    localparam logic [SPI_ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    function automatic logic [SPI_FRAME_W-1:0] spi_make_frame(
        input logic                  wr,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {wr, addr, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tick_gen.sv
// ============================================================================
//  Module   : spi_tick_gen
//  Brief    : Phase counter emitting a one-cycle tick every CLK_DIV cycles
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_tick_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/spi_controller.sv
// ============================================================================
//  Module   : spi_controller
//  Brief    : SPI mode-0 initiator sending one 16-bit command frame per request
//  Revision : 1.0
// ============================================================================
`default_nettype none

module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [SPI_DATA_W-1:0] req_data,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  COPI,
    output logic                  nCS
);

    generate
        if (CLK_DIV < 4) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must be at least 4");
        end
        if (IDLE_CYCLES < 4) begin : g_bad_idle_cycles
            $error("spi_controller: IDLE_CYCLES must be at least 4");
        end
    endgenerate

    localparam int                 c_gap_w    = $clog2(IDLE_CYCLES);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(IDLE_CYCLES - 1);

    spi_state_e              r_state, w_state_nxt;
    logic [SPI_FRAME_W-1:0]  r_shreg, w_shreg_nxt;
    logic [3:0]              r_bit_cnt, w_bit_cnt_nxt;
    logic [c_gap_w-1:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic                    r_sclk, w_sclk_nxt;
    logic                    r_copi, w_copi_nxt;
    logic                    r_ncs, w_ncs_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_busy, w_busy_nxt;
    logic                    r_ready, w_ready_nxt;

    logic                    w_accept;
    logic                    w_tick;
    logic                    w_tick_en;
    logic [SPI_FRAME_W-1:0]  w_frame;

    assign w_accept  = req_valid && r_ready;
    assign w_frame   = spi_make_frame(req_write, req_addr, req_data);
    assign w_tick_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_tick_en),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_sclk    <= 1'b0;
            r_copi    <= 1'b0;
            r_ncs     <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_sclk    <= w_sclk_nxt;
            r_copi    <= w_copi_nxt;
            r_ncs     <= w_ncs_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= w_busy_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Next values for every output register, so each pin comes straight off a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_sclk_nxt    = r_sclk;
        w_copi_nxt    = r_copi;
        w_ncs_nxt     = r_ncs;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = r_busy;
        w_ready_nxt   = r_ready;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt   = w_frame;
                    w_copi_nxt    = w_frame[SPI_FRAME_W-1];
                    w_bit_cnt_nxt = 4'd15;
                    w_sclk_nxt    = 1'b0;
                    w_ncs_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_ready_nxt   = 1'b0;
                    w_state_nxt   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Data only moves on the falling edge; the last bit stays put into HOLD.
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == 4'd0) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                            w_shreg_nxt   = {r_shreg[SPI_FRAME_W-2:0], 1'b0};
                            w_copi_nxt    = r_shreg[SPI_FRAME_W-2];
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_ncs_nxt     = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_copi_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign SCLK      = r_sclk;
    assign COPI      = r_copi;
    assign nCS       = r_ncs;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
//  Module   : tb_spi_controller
//  Brief    : Randomised scoreboard bench for spi_controller
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_controller;

    localparam int D    = 8;
    localparam int IDLE = 8;

    typedef struct {
        logic [15:0] frame;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic       SCLK;
    logic       COPI;
    logic       nCS;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    spi_controller #(
        .CLK_DIV     (D),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: write flag weighs 2^15, address 2^8, data 2^0.
    function automatic logic [15:0] frame_of(input int w, input int a, input int d);
        return 16'(w * 32768 + a * 256 + d);
    endfunction

    a_copi_stable: assert property (@(posedge clk) disable iff (!rst_n) SCLK |-> $stable(COPI))
        else begin
            errors++;
            $display("FAIL copi_stable_assert: COPI changed while SCLK high, required stable");
        end

    // ---------------- monitor / scoreboard ----------------
    logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;
    bit          active = 0, tim_ok, stab_ok;
    int          nrise, nfall, last_rise = -1000, ready_due = -1;
    logic [15:0] got;
    exp_t        m_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (active) begin
                    void'(sb_q.pop_front());
                    active = 0;
                end
                if (done) chk("done_in_reset", done, 1'b0);
                last_rise = -1000;
                ready_due = -1;
                p_ncs = nCS; p_sclk = SCLK; p_copi = COPI;
                continue;
            end
            if (cyc == ready_due - 1) chk("busy_before_return", {req_ready, busy}, 2'b01);
            if (cyc == ready_due)     chk("ready_return", {req_ready, busy}, 2'b10);
            if (done && !(p_ncs === 1'b0 && nCS === 1'b1))
                chk("spurious_done", done, 1'b0);

            if (p_ncs && !nCS) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1'b1, 1'b0);
                end else begin
                    m_e = sb_q[0];
                    chk("ncs_fall_cycle", cyc, m_e.acc + 1);
                    chk("gap_min", (cyc - last_rise) >= IDLE + 1, 1'b1);
                    chk("busy_at_fall", {busy, req_ready}, 2'b10);
                    active = 1; nrise = 0; nfall = 0; got = '0;
                    tim_ok = 1; stab_ok = 1;
                end
            end
            if (active) begin
                if (SCLK && COPI !== p_copi) stab_ok = 0;
                if (!p_sclk && SCLK) begin
                    if (cyc != m_e.acc + 1 + (2 * nrise + 1) * D) tim_ok = 0;
                    got = {got[14:0], COPI};
                    nrise++;
                end
                if (p_sclk && !SCLK) begin
                    if (cyc != m_e.acc + 1 + (2 * nfall + 2) * D) tim_ok = 0;
                    nfall++;
                end
                if (!p_ncs && nCS) begin
                    m_e = sb_q.pop_front();
                    chk("frame_bits", got, m_e.frame);
                    chk("rise_count", nrise, 16);
                    chk("ncs_rise_cycle", cyc, m_e.acc + 1 + 33 * D);
                    chk("done_at_ncs_rise", done, 1'b1);
                    chk("sclk_timing", tim_ok, 1'b1);
                    chk("copi_stable", stab_ok, 1'b1);
                    last_rise = cyc;
                    ready_due = cyc + IDLE;
                    active = 0;
                end
            end
            p_ncs = nCS; p_sclk = SCLK; p_copi = COPI;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                        input bit keep_valid, input bit toggle, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        acc     = cyc;
        e.frame = frame_of(int'(w), int'(a), int'(d));
        e.acc   = acc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = 1'b0;
        if (toggle) begin
            n = 0;
            while (busy && n < 2000) begin
                @(negedge clk);
                req_data  = 8'($urandom);
                req_addr  = 7'($urandom);
                req_write = 1'($urandom);
                n++;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && sb_q.size() == 0) && n < 3000);
        if (n >= 3000) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    int acc1, acc2, target, n;
    bit keep;

    initial begin : stimulus
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_ncs", nCS, 1'b1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", {SCLK, COPI, nCS, done, busy, req_ready}, 6'b001001);

        // directed write addr 0x00, data 0xA5
        send(1'b1, 7'h00, 8'hA5, 0, 0, acc1);
        wait_idle();

        // held-valid back-to-back requests
        send(1'b1, 7'h01, 8'hFF, 1, 0, acc1);
        send(1'b1, 7'h02, 8'h0F, 0, 0, acc2);
        chk("b2b_accept_spacing", acc2 - acc1, 1 + 33 * D + IDLE);
        wait_idle();

        // read frame
        send(1'b0, 7'h03, 8'h3C, 0, 0, acc1);
        wait_idle();

        // reset during bit 7 high phase
        send(1'b1, 7'h55, 8'h96, 0, 0, acc1);
        target = acc1 + 1 + 15 * D + 3;
        n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {nCS, SCLK, COPI, done, busy}, 5'b10000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {req_ready, nCS}, 2'b11);
        send(1'($urandom), 7'($urandom), 8'($urandom), 0, 0, acc1);
        wait_idle();

        // request inputs churn while busy
        send(1'b1, 7'h04, 8'h80, 0, 1, acc1);
        wait_idle();

        // randomised requests, sometimes back-to-back
        for (int i = 0; i < 10; i++) begin
            keep = (i != 9) && ($urandom_range(0, 1) == 1);
            send(1'($urandom), 7'($urandom), 8'($urandom), keep, 0, acc1);
            if (!keep) repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        wait_idle();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
